// File: rtl/surfctl_eye_scanner_if.sv
// Classic Wishbone initiator bundle used by surfctl_eye_scanner.
// dat_w carries master write data, dat_r carries slave read data.
interface surfctl_eye_scanner_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [5:0]  adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        output cyc, stb, we, adr, dat_w, sel,
        input  dat_r, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel,
        output dat_r, ack, err, rty
    );
endinterface

// File: rtl/surfctl_eye_scanner.sv
// surfctl_eye_scanner: steps a SURF link IDELAY through taps 0..MAX_TAP,
// reads the timed bit-error counter at each tap, finds the longest
// error-free run and programs the IDELAY to its centre.
// Optional: define SURFCTL_EYE_SCANNER_ISERDES_RESET_EN to pulse the
// ISERDES reset bit in CONTROL_REG (0x00) before the scan starts.
module surfctl_eye_scanner #(
    parameter int unsigned MAX_TAP     = 31,
    parameter int unsigned WAIT_CYCLES = 131072,
    parameter int unsigned ERR_THRESH  = 0,
    parameter int unsigned ACK_TIMEOUT = 1023
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic                         start_i,
    input  logic                         path_i,
    input  logic [23:0]                  interval_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         fail_o,
    output logic [5:0]                   eye_start_o,
    output logic [6:0]                   eye_width_o,
    output logic [5:0]                   center_o,
    surfctl_eye_scanner_if.master        wbm
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_SET_DELAY  = 4'd1;
    localparam logic [3:0] S_ARM        = 4'd2;
    localparam logic [3:0] S_WAIT       = 4'd3;
    localparam logic [3:0] S_READ       = 4'd4;
    localparam logic [3:0] S_EVAL       = 4'd5;
    localparam logic [3:0] S_SET_CENTER = 4'd6;
    localparam logic [3:0] S_FINISH     = 4'd7;
    localparam logic [3:0] S_FAIL       = 4'd8;
`ifdef SURFCTL_EYE_SCANNER_ISERDES_RESET_EN
    localparam logic [3:0] S_RST_SET    = 4'd9;
    localparam logic [3:0] S_RST_CLR    = 4'd10;
`endif

    localparam int unsigned WAIT_W = $clog2(WAIT_CYCLES + 1);
    localparam int unsigned TMO_W  = $clog2(ACK_TIMEOUT + 1);
    localparam logic [5:0]  LAST_TAP = 6'(MAX_TAP);
    localparam logic [24:0] THRESH   = 25'(ERR_THRESH);

    logic [3:0]        state_q, state_d;
    logic [5:0]        tap_q, tap_d;
    logic              path_q, path_d;
    logic [23:0]       interval_q, interval_d;
    logic [5:0]        cur_start_q, cur_start_d;
    logic [6:0]        cur_len_q, cur_len_d;
    logic [5:0]        best_start_q, best_start_d;
    logic [6:0]        best_len_q, best_len_d;
    logic [24:0]       cnt_q, cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              acked_q, acked_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic [5:0]        adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic [3:0]        sel_q, sel_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fail_q, fail_d;
    logic [5:0]        eye_start_q, eye_start_d;
    logic [6:0]        eye_width_q, eye_width_d;
    logic [5:0]        center_q, center_d;

    logic              launch;
    logic              drop;
    logic              good;
    logic [6:0]        half;
    logic [5:0]        idelay_adr;
    logic [5:0]        count_adr;

    // Next-state logic: sequencing, run tracking and bus cycle generation.
    // A bus state waits one extra cycle after its response (acked_q) so that
    // the following bus cycle is always preceded by an idle cycle.
    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        path_d       = path_q;
        interval_d   = interval_q;
        cur_start_d  = cur_start_q;
        cur_len_d    = cur_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        cnt_d        = cnt_q;
        wait_d       = wait_q;
        tmo_d        = tmo_q;
        acked_d      = acked_q;
        cyc_d        = cyc_q;
        we_d         = we_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        sel_d        = sel_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        fail_d       = fail_q;
        eye_start_d  = eye_start_q;
        eye_width_d  = eye_width_q;
        center_d     = center_q;
        launch       = 1'b0;
        drop         = 1'b0;
        good         = (cnt_q <= THRESH);
        half         = '0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    path_d       = path_i;
                    interval_d   = interval_i;
                    fail_d       = 1'b0;
                    tap_d        = '0;
                    cur_start_d  = '0;
                    cur_len_d    = '0;
                    best_start_d = '0;
                    best_len_d   = '0;
                    busy_d       = 1'b1;
`ifdef SURFCTL_EYE_SCANNER_ISERDES_RESET_EN
                    state_d      = S_RST_SET;
`else
                    state_d      = S_SET_DELAY;
`endif
                    launch       = 1'b1;
                end
            end

`ifdef SURFCTL_EYE_SCANNER_ISERDES_RESET_EN
            S_RST_SET, S_RST_CLR,
`endif
            S_SET_DELAY, S_ARM, S_READ, S_SET_CENTER: begin
                if (acked_q) begin
                    acked_d = 1'b0;
                    case (state_q)
`ifdef SURFCTL_EYE_SCANNER_ISERDES_RESET_EN
                        S_RST_SET:    begin state_d = S_RST_CLR;   launch = 1'b1; end
                        S_RST_CLR:    begin state_d = S_SET_DELAY; launch = 1'b1; end
`endif
                        S_SET_DELAY:  begin state_d = S_ARM;       launch = 1'b1; end
                        S_ARM:        begin state_d = S_WAIT;      wait_d = '0;   end
                        S_READ:       state_d = S_EVAL;
                        default:      state_d = S_FINISH;
                    endcase
                end else if (wbm.ack) begin
                    drop    = 1'b1;
                    acked_d = 1'b1;
                    if (state_q == S_READ) begin
                        if (wbm.dat_r == '1) begin
                            state_d = S_FAIL;
                            acked_d = 1'b0;
                        end else begin
                            cnt_d = wbm.dat_r[24:0];
                        end
                    end
                end else if (wbm.err || wbm.rty) begin
                    drop    = 1'b1;
                    state_d = S_FAIL;
                end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                    drop    = 1'b1;
                    state_d = S_FAIL;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_WAIT: begin
                if (wait_q == WAIT_W'(WAIT_CYCLES - 1)) begin
                    state_d = S_READ;
                    launch  = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            S_EVAL: begin
                if (good) begin
                    if (cur_len_q == '0) begin
                        cur_start_d = tap_q;
                    end
                    cur_len_d = cur_len_q + 1'b1;
                    if (cur_len_d > best_len_q) begin
                        best_start_d = cur_start_d;
                        best_len_d   = cur_len_d;
                    end
                end else begin
                    cur_len_d = '0;
                end
                if (tap_q == LAST_TAP) begin
                    if (best_len_d != '0) begin
                        half        = (best_len_d - 7'd1) >> 1;
                        center_d    = best_start_d + half[5:0];
                        eye_start_d = best_start_d;
                        eye_width_d = best_len_d;
                        state_d     = S_SET_CENTER;
                        launch      = 1'b1;
                    end else begin
                        state_d = S_FAIL;
                    end
                end else begin
                    tap_d   = tap_q + 1'b1;
                    state_d = S_SET_DELAY;
                    launch  = 1'b1;
                end
            end

            S_FINISH, S_FAIL: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        if (drop) begin
            cyc_d = 1'b0;
            we_d  = 1'b0;
            adr_d = '0;
            dat_d = '0;
            sel_d = '0;
        end

        idelay_adr = path_d ? 6'h14 : 6'h04;
        count_adr  = path_d ? 6'h18 : 6'h08;

        if (launch) begin
            cyc_d = 1'b1;
            tmo_d = '0;
            case (state_d)
`ifdef SURFCTL_EYE_SCANNER_ISERDES_RESET_EN
                S_RST_SET: begin
                    we_d = 1'b1; adr_d = 6'h00; dat_d = 32'h4; sel_d = 4'b0001;
                end
                S_RST_CLR: begin
                    we_d = 1'b1; adr_d = 6'h00; dat_d = 32'h0; sel_d = 4'b0001;
                end
`endif
                S_SET_DELAY: begin
                    we_d = 1'b1; adr_d = idelay_adr; dat_d = {26'd0, tap_d}; sel_d = 4'b0001;
                end
                S_ARM: begin
                    we_d = 1'b1; adr_d = count_adr; dat_d = {8'h0, interval_d}; sel_d = 4'b0111;
                end
                S_READ: begin
                    we_d = 1'b0; adr_d = count_adr; dat_d = '0; sel_d = 4'b1111;
                end
                default: begin
                    we_d = 1'b1; adr_d = idelay_adr; dat_d = {26'd0, center_d}; sel_d = 4'b0001;
                end
            endcase
        end

        if (state_d != state_q && (state_d == S_FINISH || state_d == S_FAIL)) begin
            done_d = 1'b1;
            if (state_d == S_FAIL) begin
                fail_d = 1'b1;
            end
        end
    end

    // State and output registers; reset aborts any bus cycle immediately.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= S_IDLE;
            tap_q        <= '0;
            path_q       <= 1'b0;
            interval_q   <= '0;
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            cnt_q        <= '0;
            wait_q       <= '0;
            tmo_q        <= '0;
            acked_q      <= 1'b0;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            eye_start_q  <= '0;
            eye_width_q  <= '0;
            center_q     <= '0;
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            path_q       <= path_d;
            interval_q   <= interval_d;
            cur_start_q  <= cur_start_d;
            cur_len_q    <= cur_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
            cnt_q        <= cnt_d;
            wait_q       <= wait_d;
            tmo_q        <= tmo_d;
            acked_q      <= acked_d;
            cyc_q        <= cyc_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            sel_q        <= sel_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            eye_start_q  <= eye_start_d;
            eye_width_q  <= eye_width_d;
            center_q     <= center_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign fail_o      = fail_q;
    assign eye_start_o = eye_start_q;
    assign eye_width_o = eye_width_q;
    assign center_o    = center_q;

    assign wbm.cyc   = cyc_q;
    assign wbm.stb   = cyc_q;
    assign wbm.we    = we_q;
    assign wbm.adr   = adr_q;
    assign wbm.dat_w = dat_q;
    assign wbm.sel   = sel_q;

endmodule

// File: tb/tb_surfctl_eye_scanner.sv
// Self-checking bench for surfctl_eye_scanner: a register-target model
// answers bus cycles, a brute-force eye search predicts the outcome.
module tb_surfctl_eye_scanner;

    localparam int MAXT  = 31;
    localparam int WAITC = 8;
    localparam int TMO   = 1023;
`ifdef SURFCTL_EYE_SCANNER_ISERDES_RESET_EN
    localparam int PRE = 2;
`else
    localparam int PRE = 0;
`endif

    typedef struct {
        logic        we;
        logic [5:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        path = 1'b0;
    logic [23:0] interval = '0;
    logic        busy, done, fail;
    logic [5:0]  eye_start, center;
    logic [6:0]  eye_width;

    surfctl_eye_scanner_if bus();

    surfctl_eye_scanner #(
        .MAX_TAP(MAXT), .WAIT_CYCLES(WAITC), .ERR_THRESH(0), .ACK_TIMEOUT(TMO)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .path_i(path),
        .interval_i(interval), .busy_o(busy), .done_o(done), .fail_o(fail),
        .eye_start_o(eye_start), .eye_width_o(eye_width), .center_o(center),
        .wbm(bus.master)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    txn_t        log_q[$];
    txn_t        exp_q[$];
    int unsigned errs[0:MAXT];
    int          fault_tap = -1;
    bit          no_ack_arm = 1'b0;
    logic [5:0]  tgt_delay[0:1];
    int          lat_left = 0;

    // expected result registers of the reference model
    logic        exp_fail = 1'b0;
    logic [5:0]  exp_es = '0;
    logic [6:0]  exp_ew = '0;
    logic [5:0]  exp_c = '0;

    // run_scan observations
    int          ndone, extra_activity, arm_cyc_cnt;
    logic        busy_at_done;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // register target: IDELAY regs remember the tap, count reads return the
    // error count of the currently programmed tap (upper bits are junk)
    initial begin
        txn_t tr;
        int   pi;
        bus.ack = 1'b0; bus.err = 1'b0; bus.rty = 1'b0; bus.dat_r = '0;
        tgt_delay[0] = '0; tgt_delay[1] = '0;
        forever begin
            @(negedge clk);
            bus.ack = 1'b0;
            bus.dat_r = '0;
            if (bus.cyc && bus.stb && !rst) begin
                if (no_ack_arm && bus.we && (bus.adr == 6'h08 || bus.adr == 6'h18)) begin
                    lat_left = 0;
                end else if (lat_left > 0) begin
                    lat_left--;
                end else begin
                    tr.we = bus.we; tr.adr = bus.adr; tr.dat = bus.dat_w; tr.sel = bus.sel;
                    log_q.push_back(tr);
                    if (bus.we && bus.adr == 6'h04) tgt_delay[0] = bus.dat_w[5:0];
                    if (bus.we && bus.adr == 6'h14) tgt_delay[1] = bus.dat_w[5:0];
                    if (!bus.we) begin
                        pi = (bus.adr == 6'h18) ? 1 : 0;
                        if (int'(tgt_delay[pi]) == fault_tap)
                            bus.dat_r = 32'hFFFF_FFFF;
                        else
                            bus.dat_r = {7'($urandom), 25'(errs[tgt_delay[pi]])};
                    end
                    bus.ack = 1'b1;
                    lat_left = $urandom_range(0, 2);
                end
            end
        end
    end

    task automatic push_exp(input logic we, input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        txn_t tr;
        tr.we = we; tr.adr = a; tr.dat = d; tr.sel = s;
        exp_q.push_back(tr);
    endtask

    // Reference: expected bus trace and result, eye found by brute force
    task automatic make_expected(input logic p, input logic [23:0] iv, input bit timeout);
        logic [5:0] ia, ca;
        int bs, bl, len;
        bit stopped;
        ia = p ? 6'h14 : 6'h04;
        ca = p ? 6'h18 : 6'h08;
        exp_q.delete();
`ifdef SURFCTL_EYE_SCANNER_ISERDES_RESET_EN
        push_exp(1'b1, 6'h00, 32'h4, 4'b0001);
        push_exp(1'b1, 6'h00, 32'h0, 4'b0001);
`endif
        if (timeout) begin
            push_exp(1'b1, ia, 32'd0, 4'b0001);
            exp_fail = 1'b1;
            return;
        end
        stopped = 1'b0;
        for (int t = 0; t <= MAXT; t++) begin
            push_exp(1'b1, ia, 32'(t), 4'b0001);
            push_exp(1'b1, ca, {8'h0, iv}, 4'b0111);
            push_exp(1'b0, ca, 32'h0, 4'b1111);
            if (t == fault_tap) begin
                stopped = 1'b1;
                break;
            end
        end
        bs = 0; bl = 0;
        for (int s = 0; s <= MAXT; s++) begin
            len = 0;
            while (s + len <= MAXT && errs[s + len] == 0) len++;
            if (len > bl) begin bl = len; bs = s; end
        end
        if (stopped || bl == 0) begin
            exp_fail = 1'b1;
        end else begin
            exp_fail = 1'b0;
            exp_es = 6'(bs);
            exp_ew = 7'(bl);
            exp_c  = 6'(bs + (bl - 1) / 2);
            push_exp(1'b1, ia, 32'(exp_c), 4'b0001);
        end
    endtask

    task automatic run_scan(input logic p, input logic [23:0] iv, input bit poke);
        int n;
        log_q.delete();
        ndone = 0; extra_activity = 0; arm_cyc_cnt = 0; busy_at_done = 1'b0;
        path = p; interval = iv;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        path = ~p; interval = 24'($urandom);
        check("busy_after_start", 64'(busy), 64'd1);
        n = 0;
        while (ndone == 0 && n < 6000) begin
            @(negedge clk);
            n++;
            start = (poke && n == 60) ? 1'b1 : 1'b0;
            if (bus.cyc && bus.we && bus.adr == (p ? 6'h18 : 6'h08)) arm_cyc_cnt++;
            if (done) begin
                ndone++;
                busy_at_done = busy;
                start = 1'b1;
            end
        end
        check("done_seen", 64'(ndone), 64'd1);
        check("busy_at_done", 64'(busy_at_done), 64'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (bus.cyc || busy || done) extra_activity++;
        end
        check("idle_after_done", 64'(extra_activity), 64'd0);
    endtask

    task automatic check_result(input string name);
        int m;
        check({name, ".fail"}, 64'(fail), 64'(exp_fail));
        check({name, ".eye_start"}, 64'(eye_start), 64'(exp_es));
        check({name, ".eye_width"}, 64'(eye_width), 64'(exp_ew));
        check({name, ".center"}, 64'(center), 64'(exp_c));
        check({name, ".txn_count"}, 64'(log_q.size()), 64'(exp_q.size()));
        m = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s.txn%0d.we_adr", name, i),
                  64'({log_q[i].we, log_q[i].adr}), 64'({exp_q[i].we, exp_q[i].adr}));
            if (exp_q[i].we)
                check($sformatf("%s.txn%0d.dat_sel", name, i),
                      64'({log_q[i].dat, log_q[i].sel}), 64'({exp_q[i].dat, exp_q[i].sel}));
        end
    endtask

    task automatic set_window(input int a, input int b, input int c, input int d);
        for (int t = 0; t <= MAXT; t++)
            errs[t] = ((t >= a && t <= b) || (t >= c && t <= d)) ? 0 : $urandom_range(1, 1 << 20);
    endtask

    initial begin
        logic [23:0] iv;
        int n;

        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'({busy, done, fail, eye_start, eye_width, center, bus.cyc, bus.stb, bus.we, bus.adr, bus.sel}),
              64'd0);
        check("reset_dat", 64'(bus.dat_w), 64'd0);
        rst = 1'b0;

        // COUT window 10..17 (bad count 500), stray start mid-scan
        for (int t = 0; t <= MAXT; t++) errs[t] = (t >= 10 && t <= 17) ? 0 : 500;
        iv = 24'($urandom);
        make_expected(1'b0, iv, 1'b0);
        run_scan(1'b0, iv, 1'b1);
        check_result("cout_window");

        // DOUT tie: first run wins
        set_window(2, 5, 20, 23);
        iv = 24'($urandom);
        make_expected(1'b1, iv, 1'b0);
        run_scan(1'b1, iv, 1'b0);
        check_result("dout_tie");

        // every tap good: full-width eye
        for (int t = 0; t <= MAXT; t++) errs[t] = 0;
        iv = 24'hFFFFFF;
        make_expected(1'b0, iv, 1'b0);
        run_scan(1'b0, iv, 1'b0);
        check_result("all_good");

        // runs touching both ends must not wrap
        set_window(0, 1, 28, 31);
        iv = 24'($urandom);
        make_expected(1'b1, iv, 1'b0);
        run_scan(1'b1, iv, 1'b0);
        check_result("no_wrap");

        // no eye: previous eye outputs retained
        for (int t = 0; t <= MAXT; t++) errs[t] = 1;
        iv = 24'($urandom);
        make_expected(1'b0, iv, 1'b0);
        run_scan(1'b0, iv, 1'b0);
        check_result("no_eye");

        // sysclk down at tap 4
        set_window(10, 17, 40, 40);
        fault_tap = 4;
        iv = 24'($urandom);
        make_expected(1'b0, iv, 1'b0);
        run_scan(1'b0, iv, 1'b0);
        check_result("sysclk_down");
        fault_tap = -1;

        // ARM write never acknowledged
        no_ack_arm = 1'b1;
        iv = 24'($urandom);
        make_expected(1'b0, iv, 1'b1);
        run_scan(1'b0, iv, 1'b0);
        check_result("ack_timeout");
        check("ack_timeout.cycles", 64'(arm_cyc_cnt), 64'(TMO));
        no_ack_arm = 1'b0;

        // fresh eye so the outputs are non-zero, then reset mid-WAIT
        set_window(6, 9, 40, 40);
        make_expected(1'b0, 24'h123, 1'b0);
        run_scan(1'b0, 24'h123, 1'b0);
        check_result("pre_reset");
        log_q.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (log_q.size() < PRE + 2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reach_wait", 64'(log_q.size() >= PRE + 2), 64'd1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs",
              64'({busy, done, fail, eye_start, eye_width, center, bus.cyc, bus.stb, bus.we, bus.adr, bus.sel}),
              64'd0);
        check("async_reset_dat", 64'(bus.dat_w), 64'd0);
        exp_es = '0; exp_ew = '0; exp_c = '0; exp_fail = 1'b0;
        @(negedge clk); rst = 1'b0;
        set_window(13, 24, 40, 40);
        iv = 24'($urandom);
        make_expected(1'b1, iv, 1'b0);
        run_scan(1'b1, iv, 1'b0);
        check_result("after_reset");

        // random patterns
        for (int r = 0; r < 3; r++) begin
            logic p;
            for (int t = 0; t <= MAXT; t++)
                errs[t] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 1 << 20) : 0;
            p = 1'($urandom);
            iv = 24'($urandom);
            make_expected(p, iv, 1'b0);
            run_scan(p, iv, 1'b0);
            check_result($sformatf("random%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
